// File: rtl/count_trk_pkg.sv
// Shared types and the next-count prediction for the mod-12 counter tracker.
package count_trk_pkg;

  localparam int         MOD     = 12;
  localparam logic [3:0] CNT_MAX = 4'(MOD - 1);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } trk_state_e;

  // Value the counter should show one edge after seeing these controls.
  function automatic logic [3:0] next_cnt(
    input logic [3:0] cnt,
    input logic       load,
    input logic       mode,
    input logic [3:0] data,
    input logic       rst
  );
    logic [3:0] nxt;
    if (rst)       nxt = 4'd0;
    else if (load) nxt = data;
    else if (mode) nxt = (cnt == CNT_MAX) ? 4'd0 : cnt + 4'd1;
    else           nxt = (cnt == 4'd0) ? CNT_MAX : cnt - 4'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/count_trk_pred.sv
// Combinational predictor: expected counter value from the previous sample.
// valid drops when the counter was told to load a value outside 0..11,
// because the counter's response to that is not defined.
module count_pred
  import count_trk_pkg::*;
(
  input  logic [3:0] p_cnt,
  input  logic       p_load,
  input  logic       p_mode,
  input  logic [3:0] p_data,
  input  logic       p_rst,
  output logic [3:0] pred,
  output logic       valid
);

  // Prediction and its trustworthiness.
  always_comb begin
    pred  = next_cnt(p_cnt, p_load, p_mode, p_data, p_rst);
    valid = p_rst || !p_load || (p_data <= CNT_MAX);
  end

endmodule

// File: rtl/count_trk.sv
// Sequence checker and wrap-event source sitting beside the mod-12 counter.
// Samples the counter controls and output every edge, predicts the next count
// and compares it with what the counter actually shows one edge later.
module count_trk
  import count_trk_pkg::*;
#(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              mode,
  input  logic [3:0]        data_in,
  input  logic [3:0]        count_in,
  input  logic              clear_err,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              step_err,
  output logic              range_err,
  output logic              err_sticky
);

  logic [3:0]        p_cnt_q, p_cnt_d;
  logic              p_load_q, p_load_d;
  logic              p_mode_q, p_mode_d;
  logic [3:0]        p_data_q, p_data_d;
  logic              p_rst_q, p_rst_d;

  trk_state_e        state_q, state_d;

  logic              wrap_up_q, wrap_up_d;
  logic              wrap_dn_q, wrap_dn_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              step_err_q, step_err_d;
  logic              range_err_q, range_err_d;
  logic              err_sticky_q, err_sticky_d;

  logic [3:0]        pred;
  logic              pred_valid;
  logic              checking;
  logic              counting;

  count_pred u_pred (
    .p_cnt  (p_cnt_q),
    .p_load (p_load_q),
    .p_mode (p_mode_q),
    .p_data (p_data_q),
    .p_rst  (p_rst_q),
    .pred   (pred),
    .valid  (pred_valid)
  );

  // Next sample: the inputs as they stand at this edge.
  always_comb begin
    p_cnt_d  = count_in;
    p_load_d = load;
    p_mode_d = mode;
    p_data_d = data_in;
    p_rst_d  = rst;
  end

  // Sample registers run through reset so the reset itself is recorded in p_rst.
  always_ff @(posedge clk) begin
    p_cnt_q  <= p_cnt_d;
    p_load_q <= p_load_d;
    p_mode_q <= p_mode_d;
    p_data_q <= p_data_d;
    p_rst_q  <= p_rst_d;
  end

  // Check results and wrap events; nothing is trusted on the SYNC sample.
  always_comb begin
    checking    = (state_q != SYNC);
    counting    = !p_rst_q && !p_load_q;
    step_err_d  = checking && pred_valid && (count_in != pred);
    range_err_d = checking && (count_in > CNT_MAX);
    wrap_up_d   = checking && counting && p_mode_q &&
                  (p_cnt_q == CNT_MAX) && (count_in == pred);
    wrap_dn_d   = checking && counting && !p_mode_q &&
                  (p_cnt_q == 4'd0) && (count_in == pred);
    wrap_cnt_d  = wrap_cnt_q;
    if ((wrap_up_d || wrap_dn_d) && (wrap_cnt_q != '1))
      wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
  end

  // Next state; clear_err takes priority over a same-cycle error.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:    state_d = clear_err ? SYNC : TRACK;
      TRACK: begin
        if (clear_err)                      state_d = SYNC;
        else if (step_err_d || range_err_d) state_d = FAULT;
      end
      FAULT:   if (clear_err) state_d = SYNC;
      default: state_d = SYNC;
    endcase
  end

  // Sticky flag follows the state being entered so it lines up with the pulse.
  always_comb begin
    err_sticky_d = (state_d == FAULT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      wrap_up_q    <= 1'b0;
      wrap_dn_q    <= 1'b0;
      wrap_cnt_q   <= '0;
      step_err_q   <= 1'b0;
      range_err_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrap_up_q    <= wrap_up_d;
      wrap_dn_q    <= wrap_dn_d;
      wrap_cnt_q   <= wrap_cnt_d;
      step_err_q   <= step_err_d;
      range_err_q  <= range_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign wrap_up    = wrap_up_q;
  assign wrap_dn    = wrap_dn_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign step_err   = step_err_q;
  assign range_err  = range_err_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_count_trk.sv
// Directed bench for count_trk: count_in is driven as the counter would show it.
module tb_count_trk;

  logic       clk = 1'b0;
  logic       rst, load, mode, clear_err;
  logic [3:0] data_in, count_in;

  logic       wrap_up, wrap_dn, step_err, range_err, err_sticky;
  logic [7:0] wrap_cnt;
  logic       w2_wrap_up, w2_wrap_dn, w2_step_err, w2_range_err, w2_err_sticky;
  logic [1:0] w2_wrap_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  count_trk dut (
    .clk(clk), .rst(rst), .load(load), .mode(mode), .data_in(data_in),
    .count_in(count_in), .clear_err(clear_err),
    .wrap_up(wrap_up), .wrap_dn(wrap_dn), .wrap_cnt(wrap_cnt),
    .step_err(step_err), .range_err(range_err), .err_sticky(err_sticky)
  );

  count_trk #(.WRAP_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .load(load), .mode(mode), .data_in(data_in),
    .count_in(count_in), .clear_err(clear_err),
    .wrap_up(w2_wrap_up), .wrap_dn(w2_wrap_dn), .wrap_cnt(w2_wrap_cnt),
    .step_err(w2_step_err), .range_err(w2_range_err), .err_sticky(w2_err_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, settle for sampling.
  task automatic cyc(input logic r, input logic ld, input logic md,
                     input logic [3:0] d, input logic [3:0] c, input logic clr);
    rst = r; load = ld; mode = md; data_in = d; count_in = c; clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic wu, input logic wd,
                            input int wc, input logic se, input logic re,
                            input logic es);
    chk({tag, ".wrap_up"},    32'(wrap_up),    32'(wu));
    chk({tag, ".wrap_dn"},    32'(wrap_dn),    32'(wd));
    chk({tag, ".wrap_cnt"},   32'(wrap_cnt),   32'(wc));
    chk({tag, ".step_err"},   32'(step_err),   32'(se));
    chk({tag, ".range_err"},  32'(range_err),  32'(re));
    chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(es));
  endtask

  // Down-count after a load: {load, data, count_in, wrap_dn, wrap_cnt}
  logic [3:0] dn_ld  [7] = '{1, 0, 0, 0, 0,  0,  0};
  logic [3:0] dn_d   [7] = '{3, 0, 0, 0, 0,  0,  0};
  logic [3:0] dn_c   [7] = '{2, 3, 2, 1, 0, 11, 10};
  logic [3:0] dn_wd  [7] = '{0, 0, 0, 0, 0,  1,  0};
  logic [3:0] dn_wc  [7] = '{1, 1, 1, 1, 1,  2,  2};

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; load = 1'b0; mode = 1'b1; data_in = 4'd0; count_in = 4'd0; clear_err = 1'b0;

    // Reset
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    expect_out("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.w2_wrap_cnt", 32'(w2_wrap_cnt), 0);

    // Up-count 0..11 then wrap to 0; first sample is the unchecked SYNC one
    for (int i = 0; i <= 12; i++) begin
      cyc(0, 0, 1, 0, 4'(i % 12), 0);
      expect_out($sformatf("up%0d", i), (i == 12), 0, (i == 12) ? 1 : 0, 0, 0, 0);
    end
    cyc(0, 0, 1, 0, 1, 0);
    expect_out("up_after", 0, 0, 1, 0, 0, 0);

    // Load 3, down-count through 0 to 11
    for (int i = 0; i < 7; i++) begin
      cyc(0, dn_ld[i][0], 0, dn_d[i], dn_c[i], 0);
      expect_out($sformatf("dn%0d", i), 0, dn_wd[i][0], int'(dn_wc[i]), 0, 0, 0);
    end

    // Step error: load 4, counter shows 5
    cyc(0, 1, 1, 4, 9, 0);
    expect_out("ld4", 0, 0, 2, 0, 0, 0);
    cyc(0, 0, 1, 0, 5, 0);
    expect_out("step5", 0, 0, 2, 1, 0, 1);
    cyc(0, 0, 1, 0, 6, 0);
    expect_out("fault_hold", 0, 0, 2, 0, 0, 1);
    cyc(0, 0, 1, 0, 7, 1);
    expect_out("clear", 0, 0, 2, 0, 0, 0);
    // In SYNC a wrong value goes unreported
    cyc(0, 0, 1, 0, 0, 0);
    expect_out("sync_skip", 0, 0, 2, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 0);
    expect_out("track_ok", 0, 0, 2, 0, 0, 0);

    // Out-of-range count
    cyc(0, 0, 1, 0, 13, 0);
    expect_out("range13", 0, 0, 2, 1, 1, 1);
    cyc(0, 1, 1, 5, 0, 0);
    expect_out("fault_step", 0, 0, 2, 1, 0, 1);
    cyc(0, 0, 1, 0, 5, 0);
    expect_out("fault_ok", 0, 0, 2, 0, 0, 1);
    cyc(0, 0, 1, 0, 6, 1);
    expect_out("clear2", 0, 0, 2, 0, 0, 0);
    cyc(0, 0, 1, 0, 7, 0);
    expect_out("at7", 0, 0, 2, 0, 0, 0);

    // Reset mid-count at 7, then restart from 0
    cyc(1, 0, 1, 0, 8, 0);
    expect_out("midrst", 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    expect_out("post0", 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 0);
    expect_out("post1", 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 2, 0);
    expect_out("post2", 0, 0, 0, 0, 0, 0);

    // Five up-wraps: 8-bit counter counts on, 2-bit counter saturates at 3
    cyc(1, 0, 1, 0, 0, 0);
    for (int i = 0; i <= 60; i++) begin
      cyc(0, 0, 1, 0, 4'(i % 12), 0);
      chk($sformatf("sat%0d.wrap_up", i), 32'(w2_wrap_up), 32'(i > 0 && i % 12 == 0));
      chk($sformatf("sat%0d.w2_cnt", i), 32'(w2_wrap_cnt), (i / 12 > 3) ? 3 : i / 12);
      if (i > 0 && i % 12 == 0)
        chk($sformatf("sat%0d.wrap_cnt", i), 32'(wrap_cnt), 32'(i / 12));
    end
    chk("sat.step_err", 32'(w2_step_err), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/count_trk.md
# count_trk

Downstream consumer of the mod-12 up/down counter. It samples the counter's control inputs and its 4-bit output on every clock and predicts each next count. It reports wrap-around events, counts them, and flags any step the counter should not have taken. It sits beside the counter in the DUT as an on-chip sequence checker and wrap-event source.

## Interface
- `WRAP_W`, default 8: width of the saturating wrap counter.
- `clk` in, 1: single clock, rising-edge.
- `rst` in, 1: synchronous, active-high reset. One clock; reset is synchronous and active-high. It is the same reset that drives the counter.
- `load` in, 1: counter load control, as driven to the counter.
- `mode` in, 1: counter direction; 1 = up, 0 = down.
- `data_in` in, 4: counter load value.
- `count_in` in, 4: counter `data_out`.
- `clear_err` in, 1: one-cycle pulse; clears error state.
- `wrap_up` out, 1: pulse on an 11→0 up-wrap.
- `wrap_dn` out, 1: pulse on a 0→11 down-wrap.
- `wrap_cnt` out, WRAP_W: total wraps in both directions; saturates at all-ones.
- `step_err` out, 1: pulse when the observed count differs from the predicted count.
- `range_err` out, 1: pulse when the observed count is greater than 11.
- `err_sticky` out, 1: high while in FAULT.

## Operation
- Sample registers `p_cnt`, `p_load`, `p_mode`, `p_data`, `p_rst` capture the inputs on every edge.
- Prediction from the previous sample:
  - `p_rst` → 0.
  - else `p_load` → `p_data`.
  - else `p_mode` = 1 → `p_cnt` = 11 ? 0 : `p_cnt` + 1.
  - else → `p_cnt` = 0 ? 11 : `p_cnt` − 1.
- A `p_data` value above 11 gives an "unpredictable" prediction. The step check is skipped for that sample and tracking resyncs to the observed value.
- FSM states: SYNC, TRACK, FAULT.
  - SYNC: entered on reset or on `clear_err`. Captures one sample with no check, then moves to TRACK.
  - TRACK: each sample is checked. A mismatch or a count above 11 pulses the matching error output and moves to FAULT.
  - FAULT: `err_sticky` = 1. Checks and wrap detection continue, and error pulses still fire. `clear_err` moves to SYNC.
- Wrap detection: requires a counting step (neither `p_load` nor `p_rst` set), a previous value of 11 (up) or 0 (down) with the matching `p_mode`, and an observed count equal to the prediction. Loads never count as wraps.
- `wrap_cnt` increments by 1 per wrap pulse and holds at 2^WRAP_W − 1. It is not cleared by `clear_err`.
- If `clear_err` and a mismatch occur in the same cycle, `clear_err` wins: the next state is SYNC and `step_err` still pulses.
- All outputs reset to 0. The state resets to SYNC.

## Timing
- Every output is registered.
- Counter controls applied at edge k produce `count_in` at edge k+1. The tracker checks that value at edge k+1, and the flags are visible in the cycle after edge k+1.
- Pulses are exactly one cycle wide. Back-to-back events produce back-to-back pulses.
- Reset asserted mid-operation: all outputs are 0 on the next cycle and the state is SYNC. The sample taken while `rst` is high sets `p_rst`, so 0 is expected on the first post-reset count. That first sample is still taken in SYNC, so it is not checked.
- The SYNC→TRACK transition costs one sample. A mismatch on the SYNC sample is not reported.

## Structure
- Package `count_trk_pkg` holds:
  - `MOD` = 12 and `CNT_MAX` = 4'd11.
  - The state enum `trk_state_e` {SYNC, TRACK, FAULT}.
  - The function `next_cnt(cnt, load, mode, data, rst)` that computes the prediction.
- Sub-module `count_pred`: combinational predictor wrapping `next_cnt`. It outputs the predicted value and a `valid` flag, which is low when `p_data` is above 11.
- Top level holds the sample registers, the FSM, wrap detection, the saturating counter and the output registers.

## Test plan
- Reset, then up-count from 0 for 12 cycles → one `wrap_up` on the 11→0 step; `wrap_cnt` = 1; no error outputs.
- Load 3, then down-count 4 cycles → counts 3,2,1,0,11; `wrap_dn` = 1 once; `wrap_cnt` increments.
- Force `count_in` = 5 when 4 is predicted → `step_err` pulses; `err_sticky` = 1 and holds; `clear_err` → `err_sticky` = 0 and the state is SYNC.
- Force `count_in` = 13 → `range_err` and `step_err` pulse; state is FAULT.
- `WRAP_W` = 2, five up-wraps → `wrap_cnt` reads 1, 2, 3, 3, 3.
- Assert `rst` mid-count at value 7 → outputs are 0 on the next cycle; after release, the counter starts from 0 with no `step_err`.
